// File: rtl/ua_ctrl_pkg.sv
// Shared definitions for the analog-switch arbiter: FSM encoding, index widths
// and the round-robin pointer helper.
package ua_ctrl_pkg;

  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = $clog2(MAX_NREQ);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_CONNECTED = 2'd2,
    ST_BREAK     = 2'd3
  } ua_state_e;

  // Pointer to the requester after idx, wrapping at n.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: lowest rotational distance from the
// start pointer wins.
module rr_pick
  import ua_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_win,
  output logic [IDX_W-1:0] o_idx
);

  int w_best_d;
  int w_dist;

  always_comb begin
    o_idx    = '0;
    o_win    = '0;
    w_best_d = NREQ;
    w_dist   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - int'(i_ptr)) % NREQ;
      if (i_req[i] && (w_dist < w_best_d)) begin
        w_best_d = w_dist;
        o_idx    = IDX_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      o_win[i] = i_req[i] && (o_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/ua_switch_arbiter.sv
// Break-before-make arbiter granting one requester at a time the shared
// analog pin through a set of transmission-gate lanes.
module ua_switch_arbiter
  import ua_ctrl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int BBM_CYCLES = 4,
  parameter int MAX_HOLD   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] sw_en,
  output logic            busy,
  output logic [2:0]      owner
);

  localparam int BBM_W  = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  ua_state_e         r_state, w_state_nxt;
  logic [BBM_W-1:0]  r_bbm_cnt, w_bbm_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]  r_owner, w_owner_nxt;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [NREQ-1:0]   w_pick_win;
  logic [NREQ-1:0]   w_own_mask;
  logic [NREQ-1:0]   r_grant;
  logic              r_busy;
  logic              r_armed;
  logic              w_own_req;
  logic              w_other_req;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_win (w_pick_win),
    .o_idx (w_pick_idx)
  );

  always_comb begin
    w_own_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_own_mask[i] = (r_owner == IDX_W'(i));
    end
  end

  assign w_own_req   = |(req & w_own_mask);
  assign w_other_req = |(req & ~w_own_mask);

  always_comb begin
    w_state_nxt    = r_state;
    w_bbm_cnt_nxt  = r_bbm_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    case (r_state)
      ST_IDLE: begin
        // r_armed holds off arbitration on the first edge after reset release
        if (r_armed && (|w_pick_win)) begin
          w_state_nxt   = ST_SETTLE;
          w_bbm_cnt_nxt = '0;
          w_owner_nxt   = w_pick_idx;
          w_ptr_nxt     = next_idx(w_pick_idx, NREQ);
        end
      end
      ST_SETTLE: begin
        if (!w_own_req) begin
          w_state_nxt   = ST_BREAK;
          w_bbm_cnt_nxt = '0;
        end else if (r_bbm_cnt == BBM_W'(BBM_CYCLES - 1)) begin
          w_state_nxt    = ST_CONNECTED;
          w_bbm_cnt_nxt  = '0;
          w_hold_cnt_nxt = '0;
        end else begin
          w_bbm_cnt_nxt = r_bbm_cnt + 1'b1;
        end
      end
      ST_CONNECTED: begin
        if (!w_own_req || ((r_hold_cnt == HOLD_W'(MAX_HOLD)) && w_other_req)) begin
          w_state_nxt    = ST_BREAK;
          w_bbm_cnt_nxt  = '0;
          w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt != HOLD_W'(MAX_HOLD)) begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_BREAK: begin
        if (r_bbm_cnt == BBM_W'(BBM_CYCLES - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_bbm_cnt_nxt = '0;
        end else begin
          w_bbm_cnt_nxt = r_bbm_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Disable opens every lane at once; the pointer keeps its fairness history
    if (!ena) begin
      w_state_nxt    = ST_IDLE;
      w_bbm_cnt_nxt  = '0;
      w_hold_cnt_nxt = '0;
      w_ptr_nxt      = r_ptr;
      w_owner_nxt    = r_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bbm_cnt  <= '0;
      r_hold_cnt <= '0;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bbm_cnt  <= w_bbm_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_grant    <= (w_state_nxt == ST_CONNECTED) ? w_own_mask : '0;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_armed    <= 1'b1;
    end
  end

  assign grant = r_grant;
  assign sw_en = r_grant;
  assign busy  = r_busy;
  assign owner = r_owner;

endmodule

// File: tb/tb_ua_switch_arbiter.sv
// Bench for ua_switch_arbiter: directed scenarios with literal checks plus a
// per-cycle comparison against a behavioural arbitration model.
module tb_ua_switch_arbiter;

  localparam int NREQ = 4;
  localparam int BBM  = 4;
  localparam int MAXH = 64;

  localparam int M_IDLE   = 0;
  localparam int M_SETTLE = 1;
  localparam int M_CONN   = 2;
  localparam int M_BREAK  = 3;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena   = 1'b1;
  logic [NREQ-1:0] req   = '0;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] sw_en;
  logic            busy;
  logic [2:0]      owner;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int m_mode, m_left, m_held, m_w, m_prio;
  bit m_ready;

  // sw_en break-before-make history
  int zero_run = BBM;
  int last_nz  = 0;

  always #5 clk = ~clk;

  ua_switch_arbiter #(.NREQ(NREQ), .BBM_CYCLES(BBM), .MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .req   (req),
    .grant (grant),
    .sw_en (sw_en),
    .busy  (busy),
    .owner (owner)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_left  = 0;
    m_held  = 0;
    m_w     = 0;
    m_prio  = 0;
    m_ready = 0;
  endtask

  task automatic model_step();
    int  i;
    bit  contested;
    if (!ena) begin
      m_mode = M_IDLE;
      m_held = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (m_ready && req != 0) begin
            for (int k = 0; k < NREQ; k++) begin
              i = (m_prio + k) % NREQ;
              if (m_mode == M_IDLE && req[i]) begin
                m_w    = i;
                m_prio = (i + 1) % NREQ;
                m_mode = M_SETTLE;
                m_left = BBM;
              end
            end
          end
        end
        M_SETTLE: begin
          if (!req[m_w]) begin
            m_mode = M_BREAK;
            m_left = BBM;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_mode = M_CONN;
              m_held = 0;
            end
          end
        end
        M_CONN: begin
          contested = (req & ~(4'(1) << m_w)) != 0;
          if (!req[m_w] || (m_held == MAXH && contested)) begin
            m_mode = M_BREAK;
            m_left = BBM;
          end else if (m_held < MAXH) begin
            m_held++;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      endcase
    end
    m_ready = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    int exp_g;
    forever begin
      @(negedge clk);
      exp_g = (m_mode == M_CONN) ? (1 << m_w) : 0;
      check("model_grant", grant, exp_g);
      check("model_sw_en", sw_en, exp_g);
      check("model_busy", busy, int'(m_mode != M_IDLE));
      check("model_owner", owner, m_w);
      check("sw_en_onehot", int'($countones(sw_en) <= 1), 1);
      if (sw_en != 0) begin
        if (last_nz != 0 && int'(sw_en) != last_nz) check("bbm_gap", zero_run, (zero_run >= BBM) ? zero_run : BBM);
        last_nz  = sw_en;
        zero_run = 0;
      end else begin
        zero_run++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    req = '0;
    ena = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] g, input int budget, output int waited);
    waited = 0;
    while (grant !== g && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("wait_grant", grant, g);
  endtask

  initial begin
    int w, n, z, b;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_sw_en", sw_en, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);

    // single requester: 4 settle cycles then connected
    req   = 4'b0010;
    rst_n = 1'b1;
    @(negedge clk);
    check("arm_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("settle_grant", grant, 0);
      check("settle_busy", busy, 1);
    end
    @(negedge clk);
    check("conn_grant", grant, 4'b0010);
    check("conn_sw_en", sw_en, 4'b0010);
    check("conn_busy", busy, 1);
    check("conn_owner", owner, 1);
    req = '0;
    repeat (12) @(negedge clk);
    check("idle_busy", busy, 0);

    // simultaneous 0 and 2: 0 first, then 2 after the full gap
    do_reset();
    req = 4'b0101;
    wait_grant(4'b0001, 20, w);
    check("rr_first_lat", w, 6);
    check("rr_first_owner", owner, 0);
    repeat (3) @(negedge clk);
    req = 4'b0100;
    z = 0;
    @(negedge clk);
    while (sw_en == 0 && z < 30) begin
      z++;
      @(negedge clk);
    end
    check("rr_gap", z, 9);
    check("rr_second", sw_en, 4'b0100);
    check("rr_second_owner", owner, 2);
    req = '0;
    repeat (12) @(negedge clk);

    // revocation of a contested grant at the hold limit
    do_reset();
    req = 4'b0010;
    wait_grant(4'b0010, 20, w);
    n = 1;
    repeat (10) begin
      @(negedge clk);
      if (grant == 4'b0010) n++;
    end
    req = 4'b1010;
    @(negedge clk);
    while (grant == 4'b0010 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("hold_len", n, 65);
    z = 0;
    while (sw_en == 0 && z < 30) begin
      z++;
      @(negedge clk);
    end
    check("revoke_gap", z, 9);
    check("revoke_grant", grant, 4'b1000);
    check("revoke_owner", owner, 3);
    req = '0;
    repeat (12) @(negedge clk);

    // request withdrawn in the second settle cycle
    do_reset();
    req = 4'b0100;
    w = 0;
    while (!busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("settle_entry", busy, 1);
    @(negedge clk);
    req = '0;
    b = 0;
    @(negedge clk);
    while (busy && b < 20) begin
      check("drop_sw_en", sw_en, 0);
      b++;
      @(negedge clk);
    end
    check("drop_break_len", b, 4);
    check("drop_idle_busy", busy, 0);

    // disable while connected, then re-enable with requests held
    do_reset();
    req = 4'b0011;
    wait_grant(4'b0001, 20, w);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("ena_off_grant", grant, 0);
    check("ena_off_busy", busy, 0);
    repeat (2) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    check("ena_on_busy", busy, 1);
    check("ena_on_grant", grant, 0);
    wait_grant(4'b0010, 20, w);
    check("ena_resettle_lat", w, 4);
    check("ena_owner", owner, 1);

    // asynchronous reset in the middle of a connected cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sw_en", sw_en, 0);
    check("async_rst_grant", grant, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_owner", owner, 0);
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
